mult_share_sched: RTL and testbench
===================================

# mult_share_sched

Two-client scheduler for the shared 8-bit signed add-shift multiplier datapath. It arbitrates round-robin between two requesters and latches the winner's operands. It then sequences the datapath through load, clear, seven add/shift steps and a final subtract/shift step, and returns the 16-bit product to the winner with a one-cycle Done pulse. The block owns no arithmetic; the datapath (A, B, X registers and 9-bit adder) stays external.

## Interface
- No parameters.
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Req  in  2  per-client request; bit i = client i.
- OpS0, OpS1  in  8  signed multiplicand of client 0/1.
- OpB0, OpB1  in  8  signed multiplier of client 0/1.
- M_val  in  1  current LSB of the datapath B register.
- Dp_AB  in  16  datapath {A, B} contents.
- Gnt  out  2  one-hot grant; held from LOAD through CAPTURE.
- Done  out  2  one-cycle pulse to the served client; Product valid that cycle.
- Product  out  16  last captured {A, B}; held until the next capture.
- Busy  out  1  high in every state except IDLE.
- Dp_S  out  8  latched multiplicand driven to the datapath for the whole job.
- Dp_B  out  8  latched multiplier, loaded into the datapath when LoadB is high.
- LoadB, Clr, Add, Sub, Shift  out  1 each  datapath controls: Clr zeroes X and A; Add/Sub act with Shift in the same cycle (add-then-arithmetic-shift).

## Operation
- States: IDLE, LOAD, CLR, BIT, LAST, CAPTURE.
- IDLE: if any Req is set, choose the winner.
  - Both Req set: the winner is the client named by the priority pointer.
  - One Req set: that client wins.
  - Latch the winner's OpS/OpB into Dp_S/Dp_B, set Gnt, and go to LOAD.
  - No Req: stay in IDLE.
- LOAD: LoadB=1, then go to CLR.
- CLR: Clr=1; load the 3-bit step counter with 0; go to BIT.
- BIT: Shift=1 and Add=M_val. Increment the counter. Go to LAST after the counter reaches 6 (7 BIT cycles total).
- LAST: Shift=1 and Sub=M_val (sign-bit correction). Go to CAPTURE.
- CAPTURE: on the exiting edge, Product<=Dp_AB, Done[winner]<=1 (registered), Gnt<=0, the pointer moves to the other client, and the state returns to IDLE.
- Controls not listed for a state are 0. Add and Sub are never high together. At most one of LoadB, Clr and Shift is high in any cycle.
- Operands are sampled only in the grant cycle. Changes to OpS/OpB or to Req during a job are ignored, and the job always completes. Done still pulses if Req was dropped.
- A Req still high in the Done cycle counts as a new request; IDLE arbitrates that cycle.
- Reset, asynchronous at any time including mid-job:
  - state IDLE, pointer = client 0;
  - Gnt, Done, Busy, all datapath controls 0;
  - Product, Dp_S, Dp_B 0.
  - No Done is produced for an aborted job.

## Timing
- Cycle 0: IDLE samples Req and grants.
- Cycle 1: LOAD (Gnt, Busy visible).
- Cycle 2: CLR.
- Cycles 3–9: BIT.
- Cycle 10: LAST.
- Cycle 11: CAPTURE.
- Cycle 12: Done high, Product valid, state IDLE. A new grant may occur in this same cycle.
- Throughput: one job per 12 cycles. Back-to-back contention alternates clients.
- Datapath contract: M_val and Dp_AB reflect register contents after the preceding edge. Dp_AB is final in CAPTURE.

## Test plan
- Single request: client 0, S=7, B=−3 (0xFD) → Gnt=01 in cycles 1–11; Done=01 and Product=0xFFEB in cycle 12 only.
- Extremes: client 1, S=0x80, B=0x80 → Product=0x4000. Then S=0x7F, B=0x80 → Product=0xC080.
- Contention: both Req held from reset with distinct operands → served in order client 0, 1, 0, 1. Done pulses exactly 12 cycles apart with matching products. Gnt is always one-hot or zero.
- Mid-job disturbance: client 0 drops Req and changes OpB in cycle 5 → the job completes with the originally latched operands, Done=01 in cycle 12, and Dp_B is unchanged throughout.
- Reset in cycle 6 of a job → all outputs 0 immediately (asynchronous), no Done afterwards. The next request is granted to client 0 when both are pending.
- Control legality: across all jobs, count Shift=1 cycles (exactly 8 per job), check that Add and Sub are never both high, and check that Sub appears only in the LAST cycle.

Source files
------------

// File: rtl/mult_share_sched.sv
// mult_share_sched: round-robin two-client scheduler for a shared 8x8 signed
// add-shift multiplier. It grants one client and latches that client's operands.
// It then walks the external datapath through load, clear, seven add/shift steps
// and one subtract/shift step, and returns the product with a one-cycle Done.
module mult_share_sched (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [1:0]         Req,
    input  logic signed [7:0]  OpS0,
    input  logic signed [7:0]  OpS1,
    input  logic signed [7:0]  OpB0,
    input  logic signed [7:0]  OpB1,
    input  logic               M_val,
    input  logic [15:0]        Dp_AB,
    output logic [1:0]         Gnt,
    output logic [1:0]         Done,
    output logic [15:0]        Product,
    output logic               Busy,
    output logic signed [7:0]  Dp_S,
    output logic signed [7:0]  Dp_B,
    output logic               LoadB,
    output logic               Clr,
    output logic               Add,
    output logic               Sub,
    output logic               Shift
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLR,
        S_BIT,
        S_LAST,
        S_CAPTURE
    } state_t;

    state_t             state_q;
    logic [2:0]         cnt_q;
    logic               ptr_q;
    logic               win_q;
    logic [1:0]         gnt_q;
    logic [1:0]         done_q;
    logic [15:0]        product_q;
    logic               busy_q;
    logic signed [7:0]  dps_q;
    logic signed [7:0]  dpb_q;
    logic               loadb_q;
    logic               clr_q;
    logic               shift_q;
    logic               bit_q;
    logic               last_q;
    logic               win_d;

    // Winner for this IDLE cycle: the pointer breaks a tie, otherwise the lone requester.
    always_comb begin
        win_d = (Req == 2'b11) ? ptr_q : Req[1];
    end

    // Sequencer: state, step counter, latched operands and all registered outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 3'd0;
            ptr_q     <= 1'b0;
            win_q     <= 1'b0;
            gnt_q     <= 2'b00;
            done_q    <= 2'b00;
            product_q <= 16'h0000;
            busy_q    <= 1'b0;
            dps_q     <= 8'sd0;
            dpb_q     <= 8'sd0;
            loadb_q   <= 1'b0;
            clr_q     <= 1'b0;
            shift_q   <= 1'b0;
            bit_q     <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            // Strobes default low; each state raises only what the next state needs.
            done_q  <= 2'b00;
            loadb_q <= 1'b0;
            clr_q   <= 1'b0;
            shift_q <= 1'b0;
            bit_q   <= 1'b0;
            last_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (|Req) begin
                        win_q   <= win_d;
                        gnt_q   <= win_d ? 2'b10 : 2'b01;
                        dps_q   <= win_d ? OpS1 : OpS0;
                        dpb_q   <= win_d ? OpB1 : OpB0;
                        busy_q  <= 1'b1;
                        loadb_q <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    clr_q   <= 1'b1;
                    state_q <= S_CLR;
                end
                S_CLR: begin
                    cnt_q   <= 3'd0;
                    shift_q <= 1'b1;
                    bit_q   <= 1'b1;
                    state_q <= S_BIT;
                end
                S_BIT: begin
                    shift_q <= 1'b1;
                    if (cnt_q == 3'd6) begin
                        last_q  <= 1'b1;
                        state_q <= S_LAST;
                    end else begin
                        cnt_q   <= cnt_q + 3'd1;
                        bit_q   <= 1'b1;
                    end
                end
                S_LAST: begin
                    state_q <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    product_q <= Dp_AB;
                    done_q    <= win_q ? 2'b10 : 2'b01;
                    gnt_q     <= 2'b00;
                    busy_q    <= 1'b0;
                    ptr_q     <= ~win_q;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Add/Sub follow the live multiplier LSB; the sign bit's weight is negative, hence Sub last.
    always_comb begin
        Add = bit_q & M_val;
        Sub = last_q & M_val;
    end

    assign Gnt     = gnt_q;
    assign Done    = done_q;
    assign Product = product_q;
    assign Busy    = busy_q;
    assign Dp_S    = dps_q;
    assign Dp_B    = dpb_q;
    assign LoadB   = loadb_q;
    assign Clr     = clr_q;
    assign Shift   = shift_q;

endmodule

// File: tb/tb_mult_share_sched.sv
// Bench for mult_share_sched: models the external A/B datapath and checks
// grant, done, product and control sequencing against hand-computed values.
module tb_mult_share_sched;

    logic        Clk;
    logic        Reset_n;
    logic [1:0]  Req;
    logic [7:0]  OpS0, OpS1, OpB0, OpB1;
    logic        M_val;
    logic [15:0] Dp_AB;
    logic [1:0]  Gnt, Done;
    logic [15:0] Product;
    logic        Busy;
    logic [7:0]  Dp_S, Dp_B;
    logic        LoadB, Clr, Add, Sub, Shift;

    int n_tests = 0;
    int n_fail  = 0;

    mult_share_sched dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Req     (Req),
        .OpS0    (OpS0),
        .OpS1    (OpS1),
        .OpB0    (OpB0),
        .OpB1    (OpB1),
        .M_val   (M_val),
        .Dp_AB   (Dp_AB),
        .Gnt     (Gnt),
        .Done    (Done),
        .Product (Product),
        .Busy    (Busy),
        .Dp_S    (Dp_S),
        .Dp_B    (Dp_B),
        .LoadB   (LoadB),
        .Clr     (Clr),
        .Add     (Add),
        .Sub     (Sub),
        .Shift   (Shift)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // External datapath model: A accumulator, B multiplier, 9-bit adder.
    logic [7:0] mA = 8'h00;
    logic [7:0] mB = 8'h00;
    logic [8:0] sum9;

    always_comb begin
        sum9 = {mA[7], mA};
        if (Add)      sum9 = {mA[7], mA} + {Dp_S[7], Dp_S};
        else if (Sub) sum9 = {mA[7], mA} - {Dp_S[7], Dp_S};
    end

    always @(posedge Clk) begin
        if (LoadB) mB <= Dp_B;
        if (Clr)   mA <= 8'h00;
        if (Shift) begin
            mA <= sum9[8:1];
            mB <= {sum9[0], mB[7:1]};
        end
    end

    assign M_val = mB[0];
    assign Dp_AB = {mA, mB};

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset;
        Reset_n = 1'b0;
        Req  = 2'b00;
        OpS0 = 8'h00; OpS1 = 8'h00; OpB0 = 8'h00; OpB1 = 8'h00;
        tick;
        tick;
        n_tests++;
        if ({Gnt, Done, Busy, LoadB, Clr, Add, Sub, Shift, Product, Dp_S, Dp_B} !== 42'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got gnt=%b done=%b busy=%b prod=%h s=%h b=%h exp all zero",
                     Gnt, Done, Busy, Product, Dp_S, Dp_B);
        end
        Reset_n = 1'b1;
        tick;
        n_tests++;
        if (Busy !== 1'b0 || Gnt !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_idle got busy=%b gnt=%b exp 0 00", Busy, Gnt);
        end
    endtask

    task automatic test_single;
        logic [7:0] bv;
        logic [1:0] eg, ed;
        logic       ea, es;
        int         shifts;
        bv = 8'hFD;
        Req = 2'b01; OpS0 = 8'h07; OpB0 = bv;
        shifts = 0;
        for (int c = 1; c <= 12; c++) begin
            tick;
            if (c == 1) Req = 2'b00;
            eg = (c <= 11) ? 2'b01 : 2'b00;
            ed = (c == 12) ? 2'b01 : 2'b00;
            ea = (c >= 3 && c <= 9) ? bv[c-3] : 1'b0;
            es = (c == 10) ? bv[7] : 1'b0;
            n_tests++;
            if (Gnt !== eg) begin n_fail++; $display("FAIL single_gnt c=%0d got %b exp %b", c, Gnt, eg); end
            n_tests++;
            if (Done !== ed) begin n_fail++; $display("FAIL single_done c=%0d got %b exp %b", c, Done, ed); end
            n_tests++;
            if (Busy !== (c <= 11)) begin n_fail++; $display("FAIL single_busy c=%0d got %b", c, Busy); end
            n_tests++;
            if (LoadB !== (c == 1) || Clr !== (c == 2)) begin
                n_fail++; $display("FAIL single_ldclr c=%0d got loadb=%b clr=%b", c, LoadB, Clr);
            end
            n_tests++;
            if (Add !== ea || Sub !== es) begin
                n_fail++; $display("FAIL single_addsub c=%0d got add=%b sub=%b exp %b %b", c, Add, Sub, ea, es);
            end
            if (Shift === 1'b1) shifts++;
            if (c == 12) begin
                n_tests++;
                if (Product !== 16'hFFEB) begin
                    n_fail++; $display("FAIL single_product got %h exp FFEB", Product);
                end
            end
        end
        n_tests++;
        if (shifts != 8) begin n_fail++; $display("FAIL single_shifts got %0d exp 8", shifts); end
        tick;
        n_tests++;
        if (Done !== 2'b00) begin n_fail++; $display("FAIL single_done_pulse got %b exp 00", Done); end
    endtask

    task automatic test_extremes;
        logic [7:0]  s_tab [2];
        logic [15:0] p_tab [2];
        int          shifts;
        s_tab = '{8'h80, 8'h7F};
        p_tab = '{16'h4000, 16'hC080};
        for (int j = 0; j < 2; j++) begin
            Req = 2'b10; OpS1 = s_tab[j]; OpB1 = 8'h80;
            shifts = 0;
            for (int c = 1; c <= 12; c++) begin
                tick;
                if (c == 1) Req = 2'b00;
                n_tests++;
                if (Gnt !== ((c <= 11) ? 2'b10 : 2'b00)) begin
                    n_fail++; $display("FAIL ext_gnt job=%0d c=%0d got %b", j, c, Gnt);
                end
                n_tests++;
                if (Add !== 1'b0 || Sub !== (c == 10)) begin
                    n_fail++; $display("FAIL ext_addsub job=%0d c=%0d got add=%b sub=%b", j, c, Add, Sub);
                end
                if (Shift === 1'b1) shifts++;
                if (c == 12) begin
                    n_tests++;
                    if (Done !== 2'b10 || Product !== p_tab[j]) begin
                        n_fail++;
                        $display("FAIL ext_product job=%0d got done=%b prod=%h exp 10 %h", j, Done, Product, p_tab[j]);
                    end
                end
            end
            n_tests++;
            if (shifts != 8) begin n_fail++; $display("FAIL ext_shifts job=%0d got %0d exp 8", j, shifts); end
        end
        tick;
    endtask

    task automatic test_contention;
        int n_done;
        logic [1:0]  exp_d;
        logic [15:0] exp_p;
        Reset_n = 1'b0;
        Req  = 2'b11;
        OpS0 = 8'h05; OpB0 = 8'h03;
        OpS1 = 8'hFE; OpB1 = 8'h09;
        tick;
        tick;
        Reset_n = 1'b1;
        n_done = 0;
        for (int c = 1; c <= 52; c++) begin
            tick;
            n_tests++;
            if (!(Gnt === 2'b00 || Gnt === 2'b01 || Gnt === 2'b10)) begin
                n_fail++; $display("FAIL cont_gnt_onehot c=%0d got %b", c, Gnt);
            end
            if (Done !== 2'b00) begin
                exp_d = n_done[0] ? 2'b10 : 2'b01;
                exp_p = n_done[0] ? 16'hFFEE : 16'h000F;
                n_tests++;
                if (Done !== exp_d || c != 12 * (n_done + 1) || Product !== exp_p) begin
                    n_fail++;
                    $display("FAIL cont_done c=%0d got done=%b prod=%h exp c=%0d done=%b prod=%h",
                             c, Done, Product, 12 * (n_done + 1), exp_d, exp_p);
                end
                n_done++;
            end
            if (c == 37) Req = 2'b00;
        end
        n_tests++;
        if (n_done != 4) begin n_fail++; $display("FAIL cont_count got %0d exp 4", n_done); end
    endtask

    task automatic test_disturb;
        Req = 2'b01; OpS0 = 8'h12; OpB0 = 8'h0A;
        for (int c = 1; c <= 12; c++) begin
            tick;
            if (c == 5) begin
                Req  = 2'b00;
                OpB0 = 8'h55;
            end
            n_tests++;
            if (Dp_B !== 8'h0A || Dp_S !== 8'h12) begin
                n_fail++; $display("FAIL dist_operands c=%0d got s=%h b=%h exp 12 0A", c, Dp_S, Dp_B);
            end
            n_tests++;
            if (Done !== ((c == 12) ? 2'b01 : 2'b00)) begin
                n_fail++; $display("FAIL dist_done c=%0d got %b", c, Done);
            end
            if (c == 12) begin
                n_tests++;
                if (Product !== 16'h00B4) begin
                    n_fail++; $display("FAIL dist_product got %h exp 00B4", Product);
                end
            end
        end
        tick;
    endtask

    // Runs after test_disturb, which leaves the pointer on client 1.
    task automatic test_reset_midjob;
        Req = 2'b10; OpS1 = 8'h33; OpB1 = 8'h44;
        for (int c = 1; c <= 6; c++) begin
            tick;
            if (c == 1) Req = 2'b00;
        end
        n_tests++;
        if (Gnt !== 2'b10 || Busy !== 1'b1) begin
            n_fail++; $display("FAIL mid_running got gnt=%b busy=%b exp 10 1", Gnt, Busy);
        end
        #2;
        Reset_n = 1'b0;
        #1;
        n_tests++;
        if ({Gnt, Done, Busy, LoadB, Clr, Add, Sub, Shift, Product, Dp_S, Dp_B} !== 42'd0) begin
            n_fail++;
            $display("FAIL mid_async_reset got gnt=%b done=%b busy=%b shift=%b prod=%h s=%h b=%h exp all zero",
                     Gnt, Done, Busy, Shift, Product, Dp_S, Dp_B);
        end
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick;
            n_tests++;
            if (Done !== 2'b00 || Busy !== 1'b0) begin
                n_fail++; $display("FAIL mid_no_done c=%0d got done=%b busy=%b exp 00 0", c, Done, Busy);
            end
        end
        Req = 2'b11;
        tick;
        Req = 2'b00;
        n_tests++;
        if (Gnt !== 2'b01) begin n_fail++; $display("FAIL mid_ptr_reset got gnt=%b exp 01", Gnt); end
        for (int c = 2; c <= 12; c++) tick;
        n_tests++;
        if (Done !== 2'b01 || Product !== 16'h05FA) begin
            n_fail++; $display("FAIL mid_next_job got done=%b prod=%h exp 01 05FA", Done, Product);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_extremes;
        test_contention;
        test_disturb;
        test_reset_midjob;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
